serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 166 ++++++++++++++++
 tb/tb_serial_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are captured on start, summed LSB-first one bit
// per clock through a NAND-built full-adder slice, and the result is published on done.

module ha_nand (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    logic n_xy;
    logic n_x;
    logic n_y;

    // Classic four-NAND XOR; the shared first gate also yields the carry.
    assign n_xy = ~(x & y);
    assign n_x  = ~(x & n_xy);
    assign n_y  = ~(y & n_xy);
    assign s    = ~(n_x & n_y);
    assign c    = ~n_xy;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] sra_q,    sra_d;
    logic [WIDTH-1:0] srb_q,    srb_d;
    logic [WIDTH-2:0] sum_q,    sum_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic             cout_q,   cout_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Full-adder slice on the current LSBs and the running carry.
    logic ha0_s;
    logic ha0_c;
    logic sum_bit;
    logic ha1_c;
    logic carry_new;

    ha_nand u_ha0 (
        .x (sra_q[0]),
        .y (srb_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    ha_nand u_ha1 (
        .x (ha0_s),
        .y (carry_q),
        .s (sum_bit),
        .c (ha1_c)
    );

    assign carry_new = ha0_c | ha1_c;

    // The sum register keeps only the WIDTH-1 bits already produced; the
    // final bit comes straight from the slice on the completing edge.
    logic [WIDTH-1:0] sum_cat;
    assign sum_cat = {sum_bit, sum_q};

    always_comb begin
        state_d = state_q;
        sra_d   = sra_q;
        srb_d   = srb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ADD;
                    sra_d   = a;
                    srb_d   = b;
                    sum_d   = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ADD: begin
                sra_d   = {1'b0, sra_q[WIDTH-1:1]};
                srb_d   = {1'b0, srb_q[WIDTH-1:1]};
                sum_d   = sum_cat[WIDTH-1:1];
                carry_d = carry_new;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    s_d     = sum_cat;
                    cout_d  = carry_new;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sra_q   <= '0;
            srb_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sra_q   <= sra_d;
            srb_q   <= srb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed bench for serial_adder (WIDTH=8): expected sums are
// queued at each accepted start and checked by an independent done monitor.

module tb_serial_adder;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [WIDTH:0] sb[$];
    logic [WIDTH:0] held_exp = '0;
    logic           prev_done = 1'b0;
    int             done_seen = 0;

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic c);
        int total;
        total = int'(x) + int'(y) + int'(c);
        return total[WIDTH:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on each done and checks result hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                done_seen++;
                chk("done_not_consecutive", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got {cout,s}=0x%0h, expected no done", {cout, s});
                end else begin
                    held_exp = sb.pop_front();
                    chk("sum", 32'({cout, s}), 32'(held_exp));
                end
            end else begin
                chk("result_hold", 32'({cout, s}), 32'(held_exp));
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // One addition: accept, scramble inputs, then time busy and done.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tc, input bit poke);
        int  lat;
        int  busy_cnt;
        bit  got;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sum(ta, tb_v, tc));
        #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        lat = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (poke && lat == 3) begin
                start = 1'b1; a = '1; b = '1; cin = 1'b1;
            end
            if (poke && lat == 6) start = 1'b0;
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no done in 40 cycles, expected done at cycle %0d", WIDTH + 1);
        end else begin
            chk("done_latency", 32'(lat), 32'(WIDTH + 1));
            chk("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
        end
        $display("op a=%02h b=%02h cin=%0d -> s=%02h cout=%0d lat=%0d", ta, tb_v, tc, s, cout, lat);
    endtask

    initial begin
        int first_at;
        int second_at;
        int lat;
        int dones_before;

        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s",    32'(s),    32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero sum, carry-out overflow, and start poked during ADD.
        run_op(8'h00, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (12) @(negedge clk);

        // Back-to-back with start held high.
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sum(8'hA5, 8'h5A, 1'b1));
        #1;
        a = 8'h3C; b = 8'h0F; cin = 1'b0;
        sb.push_back(ref_sum(8'h3C, 8'h0F, 1'b0));
        lat = 0; first_at = 0; second_at = 0;
        for (int i = 0; i < 40 && second_at == 0; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                if (first_at == 0) first_at = lat;
                else second_at = lat;
            end
            if (first_at != 0 && lat == first_at + 2) begin
                start = 1'b0;
                a = WIDTH'($urandom); b = WIDTH'($urandom);
            end
        end
        start = 1'b0;
        chk("b2b_first_done",  32'(first_at),  32'(WIDTH + 1));
        chk("b2b_second_done", 32'(second_at), 32'(2 * WIDTH + 3));
        $display("op b2b A5+5A+1 then 3C+0F -> dones at %0d and %0d", first_at, second_at);

        // Asynchronous reset in the middle of an addition.
        @(negedge clk);
        a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        sb.push_back(ref_sum(8'h77, 8'h11, 1'b0));
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_s",    32'(s),    32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        sb.delete();
        held_exp = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        dones_before = done_seen;
        repeat (15) @(negedge clk);
        chk("no_done_after_abort", 32'(done_seen - dones_before), 32'd0);
        $display("op reset mid-ADD of 77+11 -> abandoned");
        run_op(8'h01, 8'h01, 1'b0, 1'b0);

        // Random sweep with random idle gaps.
        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
        end
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
